// File: rtl/ifid_pkg.sv
// Shared opcodes, immediate formats and decoded-field layout for the IF/ID stage buffer.
package ifid_pkg;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    // Fixed-width decoded fields; the XLEN-wide entry wraps these in the top.
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] read_reg2;
        logic [4:0] read_reg1;
        logic [2:0] funct3;
        logic [4:0] write_addr;
        logic [6:0] opcode;
    } ifid_fields_t;

    function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
        imm_fmt_e fmt;
        case (op)
            OP_IMM, LOAD, JALR: fmt = FMT_I;
            STORE:              fmt = FMT_S;
            BRANCH:             fmt = FMT_B;
            LUI, AUIPC:         fmt = FMT_U;
            JAL:                fmt = FMT_J;
            default:            fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

    function automatic ifid_fields_t split_fields(input logic [31:0] instr);
        ifid_fields_t f;
        f.funct7     = instr[31:25];
        f.read_reg2  = instr[24:20];
        f.read_reg1  = instr[19:15];
        f.funct3     = instr[14:12];
        f.write_addr = instr[11:7];
        f.opcode     = instr[6:0];
        return f;
    endfunction

endpackage

// File: rtl/ifid_imm_gen.sv
// Combinational immediate generator: selects the format from the opcode and sign-extends to XLEN.
module ifid_imm_gen
    import ifid_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e    fmt;
    logic [31:0] imm32;

    always_comb begin
        fmt   = imm_fmt(instr[6:0]);
        imm32 = '0;
        case (fmt)
            FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm32 = {instr[31:12], 12'b0};
            FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        // Signed size cast replicates bit 31 up to XLEN.
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/ifid_stage_buf.sv
// Elastic IF/ID stage: DEPTH-entry FIFO of pre-decoded instructions with valid/ready on both sides.
// Optional perf counters (stall_cnt, flush_cnt) are enabled by defining IFID_PERF_CNT_EN.
module ifid_stage_buf
    import ifid_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [XLEN-1:0]              if_pc,
    input  logic [31:0]                  if_instr,
    input  logic                         flush,
    input  logic                         id_ready,
    output logic                         id_valid,
    output logic [XLEN-1:0]              id_pc,
    output logic [6:0]                   opcode,
    output logic [4:0]                   write_addr,
    output logic [2:0]                   funct3,
    output logic [4:0]                   read_reg1,
    output logic [4:0]                   read_reg2,
    output logic [6:0]                   funct7,
    output logic [XLEN-1:0]              immediate,
`ifdef IFID_PERF_CNT_EN
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             flush_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        ifid_fields_t    fields;
        logic [XLEN-1:0] imm;
    } ifid_entry_t;

    if (DEPTH < 1 || DEPTH > 4 || (XLEN != 32 && XLEN != 64) || CNT_W < 1) begin : g_param_check
        $error("ifid_stage_buf: unsupported XLEN/DEPTH/CNT_W");
    end

    ifid_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             push;
    logic             pop;
    logic [XLEN-1:0]  new_imm;
    ifid_entry_t      new_entry;
    ifid_entry_t      head;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        // Explicit wrap so non-power-of-two depths stay in range.
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    ifid_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .instr (if_instr),
        .imm   (new_imm)
    );

    assign if_ready  = (occ < OCC_W'(DEPTH)) || id_ready;
    assign id_valid  = (occ != '0);
    assign push      = if_valid && if_ready && !flush;
    assign pop       = id_valid && id_ready && !flush;
    assign occupancy = occ;

    always_comb begin
        new_entry        = '0;
        new_entry.pc     = if_pc;
        new_entry.fields = split_fields(if_instr);
        new_entry.imm    = new_imm;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // An empty buffer presents an all-zero bubble (opcode 0).
    always_comb begin
        head = id_valid ? mem[rd_ptr] : '0;
    end

    assign id_pc      = head.pc;
    assign opcode     = head.fields.opcode;
    assign write_addr = head.fields.write_addr;
    assign funct3     = head.fields.funct3;
    assign read_reg1  = head.fields.read_reg1;
    assign read_reg2  = head.fields.read_reg2;
    assign funct7     = head.fields.funct7;
    assign immediate  = head.imm;

`ifdef IFID_PERF_CNT_EN
    // Saturating stall and flush event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (id_valid && !id_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`endif

endmodule
